// File: rtl/mem_pkg.sv
// Shared types for the CPU-to-32-bit-memory bridge: FSM states, memwrite codes, timer width.
package mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StWait0,
    StIssue1,
    StWait1,
    StDone
  } state_e;

  // memwrite encodings; 2'b11 is treated as a dword write as well
  localparam logic [1:0] MwRead  = 2'b00;
  localparam logic [1:0] MwWord  = 2'b01;
  localparam logic [1:0] MwDword = 2'b10;

  // Wide enough for LAT-1 with LAT up to 7
  localparam int unsigned TimerW = 3;

endpackage

// File: rtl/mem_bridge_if.sv
// CPU request/response and 32-bit memory beat signals of the bridge, grouped in one bundle.
interface mem_bridge_if #(
  parameter int unsigned N  = 64,
  parameter int unsigned AW = 32
) ();

  logic          req;
  logic [1:0]    memwrite;
  logic          dword;
  logic [N-1:0]  dataadr;
  logic [N-1:0]  writedata;
  logic [N-1:0]  readdata;
  logic          ready;
  logic          err;
  logic          busy;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  // slave: the bridge itself; master: the CPU plus memory environment around it
  modport slave (
    input  req, memwrite, dword, dataadr, writedata, m_rdata,
    output readdata, ready, err, busy, m_en, m_we, m_adr, m_wdata
  );

  modport master (
    output req, memwrite, dword, dataadr, writedata, m_rdata,
    input  readdata, ready, err, busy, m_en, m_we, m_adr, m_wdata
  );

endinterface

// File: rtl/beat_timer.sv
// Down-counter that measures the memory read latency; done is high while the count is zero.
module beat_timer
  import mem_pkg::*;
#(
  parameter int unsigned W = TimerW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_bridge.sv
// Splits N-bit CPU accesses into one or two big-endian 32-bit memory beats with fixed read latency.
module mem_bridge
  import mem_pkg::*;
#(
  parameter int unsigned N   = 64,
  parameter int unsigned AW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  mem_bridge_if.slave  bus,
  output logic [15:0]  acc_cnt
);

  state_e state_q, state_d;

  logic [AW-1:0] adr_q;
  logic [63:0]   wdata_q;
  logic          we_q, dw_q, err_q;
  logic [63:0]   rdata_q;
  logic [15:0]   acc_q;

  logic          acc_we, acc_dw, acc_err;
  logic [63:0]   wdata_ext;
  logic          tmr_load, tmr_dec, tmr_done;
  logic          unused_bits;

  // Decode of the request as seen in IDLE
  always_comb begin
    acc_we = 1'b0;
    acc_dw = bus.dword;
    case (bus.memwrite)
      MwRead: begin
        acc_we = 1'b0;
        acc_dw = bus.dword;
      end
      MwWord: begin
        acc_we = 1'b1;
        acc_dw = 1'b0;
      end
      default: begin
        acc_we = 1'b1;
        acc_dw = 1'b1;
      end
    endcase
    if (N == 32) begin
      acc_dw = 1'b0;
    end
    acc_err = (bus.dataadr[1:0] != 2'b00) || (acc_dw && bus.dataadr[2]);
  end

  assign wdata_ext = 64'(bus.writedata);

  beat_timer #(
    .W(TimerW)
  ) u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TimerW'(LAT - 1)),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          state_d = acc_err ? StDone : StIssue0;
        end
      end
      StIssue0: begin
        if (we_q) begin
          state_d = dw_q ? StIssue1 : StDone;
        end else begin
          state_d  = StWait0;
          tmr_load = 1'b1;
        end
      end
      StWait0: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = dw_q ? StIssue1 : StDone;
        end
      end
      StIssue1: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          state_d  = StWait1;
          tmr_load = 1'b1;
        end
      end
      StWait1: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory beat outputs; high word goes first for a dword write
  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_adr   = '0;
    bus.m_wdata = '0;
    if (state_q == StIssue0) begin
      bus.m_en  = 1'b1;
      bus.m_we  = we_q;
      bus.m_adr = adr_q;
      if (we_q) begin
        bus.m_wdata = dw_q ? wdata_q[63:32] : wdata_q[31:0];
      end
    end else if (state_q == StIssue1) begin
      bus.m_en  = 1'b1;
      bus.m_we  = we_q;
      bus.m_adr = adr_q + AW'(4);
      if (we_q) begin
        bus.m_wdata = wdata_q[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dw_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && bus.req) begin
        adr_q   <= bus.dataadr[AW-1:0];
        wdata_q <= wdata_ext;
        we_q    <= acc_we;
        dw_q    <= acc_dw;
        err_q   <= acc_err;
      end
      if ((state_q == StWait0) && tmr_done) begin
        if (dw_q) begin
          rdata_q[63:32] <= bus.m_rdata;
        end else begin
          rdata_q <= {32'h0, bus.m_rdata};
        end
      end
      if ((state_q == StWait1) && tmr_done) begin
        rdata_q[31:0] <= bus.m_rdata;
      end
      if ((state_q == StDone) && !err_q && (acc_q != 16'hFFFF)) begin
        acc_q <= acc_q + 16'd1;
      end
    end
  end

  assign bus.readdata = rdata_q[N-1:0];
  assign bus.ready    = (state_q == StDone);
  assign bus.err      = (state_q == StDone) && err_q;
  assign bus.busy     = (state_q != StIdle);
  assign acc_cnt      = acc_q;

  // Address bits above AW and readdata bits above N are not needed for every configuration
  assign unused_bits = ^{bus.dataadr, rdata_q};

endmodule
